digit_stream_tx: RTL and testbench
==================================

Name: digit_stream_tx

Overview:
- Parametrised successor to the decimal-digit sender used by the keylock display/link path.
- On a level enable, captures a binary value, converts it sequentially to NUM_DIGITS BCD digits, and transmits them one symbol at a time on a SYM_W-bit parallel bus qualified by a control strobe.
- Adds sequential double-dabble conversion (no combinational divide), configurable digit order, optional leading-zero suppression, a programmable inter-symbol gap, and clean abort.
- Sits between the keylock control FSM and the output pins; the per-symbol timing lives in one sub-module.

Parameters:
- NUM_W, 32, width of input value.
- NUM_DIGITS, 6, decimal digits transmitted (1..10).
- SYM_W, 4, symbol bus width; digit truncated to low SYM_W bits if SYM_W<4.
- HOLD_CYCLES, 1200000, cycles the strobe and data are held per symbol (0.1 s at 12 MHz); must be >=1.
- GAP_CYCLES, 120000, cycles of idle bus between symbols; must be >=1.
- MSD_FIRST, 1, 1 = most significant digit first, 0 = least significant first.
- SUPPRESS_LZ, 0, 1 = skip leading zeros (always send at least one digit).

Ports:
- hwclk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- enabled  input  1  level request; rising from 0 starts a transfer, low aborts/rearms.
- num  input  NUM_W  value to send; sampled on the cycle enabled is first seen high in IDLE.
- sym_out  output  SYM_W  current digit symbol.
- controlOut  output  1  high while sym_out is valid (hold phase).
- busy  output  1  high from capture until DONE.
- done  output  1  high in DONE; held until enabled drops.

Behaviour:
- Interface: one clock hwclk; reset rst is asynchronous and active-high.
- Reset (any time, including mid-transfer): state IDLE; sym_out=0, controlOut=0, busy=0, done=0; counters and digit registers cleared.
- States: IDLE, CONVERT, SELECT, HOLD, GAP, DONE.
- IDLE: if enabled=1, latch num into shift register, clear BCD register, busy=1 -> CONVERT.
- CONVERT: double-dabble, one input bit per cycle, exactly NUM_W cycles (add-3 to every BCD nibble >=5, then shift left). Keep the low NUM_DIGITS nibbles; values >=10^NUM_DIGITS are sent modulo 10^NUM_DIGITS. -> SELECT.
- SELECT (1 cycle): set digit index to NUM_DIGITS-1 (MSD_FIRST=1) or 0. If SUPPRESS_LZ=1 and MSD_FIRST=1, start at the highest nonzero digit, or at digit 0 if all digits are zero. If SUPPRESS_LZ=1 and MSD_FIRST=0, set the final index to the highest nonzero digit. -> HOLD.
- HOLD: sym_out=digit[idx][SYM_W-1:0], controlOut=1 for exactly HOLD_CYCLES cycles. Then, if idx is the last digit -> DONE; else -> GAP.
- GAP: sym_out=0, controlOut=0 for exactly GAP_CYCLES cycles; step idx (decrement for MSD_FIRST=1, else increment) -> HOLD.
- DONE: done=1, busy=0, bus idle. When enabled=0 -> IDLE (done=0 the next cycle).
- Latency: enabled high at edge k (in IDLE) -> controlOut first high at edge k+NUM_W+2.
- Abort: enabled=0 in CONVERT/SELECT/HOLD/GAP -> IDLE next cycle with controlOut=0, sym_out=0, busy=0, done not asserted. A truncated hold is allowed.
- Re-arm: a new transfer needs enabled to be low for at least one cycle (seen in IDLE) after DONE. num changes after capture are ignored.
- Outputs are registered. sym_out never changes while controlOut=1.
- Counters: hold/gap counter width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1); digit index width is $clog2(NUM_DIGITS); no wrap beyond the last digit.

Decomposition:
- Package digit_stream_pkg: state enum, BCD nibble width constant (4), and a function giving the double-dabble BCD width for NUM_W.
- Sub-module symbol_timer: holds one symbol for HOLD_CYCLES then idles for GAP_CYCLES.
  - Ports: start, sym_in, last, sym_out, controlOut, done_pulse.
  - The top FSM owns conversion and indexing.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=2, NUM_W=20, NUM_DIGITS=6 unless stated):
- Basic MSD first: num=123456, enabled held high -> symbols 1,2,3,4,5,6, each with controlOut high for 4 cycles and 2 idle cycles between. First strobe 22 cycles after capture. done rises after the last hold.
- LSD first with leading-zero suppression: MSD_FIRST=0, SUPPRESS_LZ=1, num=907 -> symbols 7,0,9 only. With num=0 -> single symbol 0, then done.
- Overflow/truncation: NUM_DIGITS=3, num=98765 -> 7,6,5. With SYM_W=3, num=000089 -> six symbols 0,0,0,0,0,1 (8->0, 9->1).
- Abort: drop enabled during the 3rd hold of 123456 -> controlOut=0 and busy=0 next cycle, done never asserted. Re-raise enabled with num=42 -> 0,0,0,0,4,2.
- Async reset: assert rst between clock edges mid-GAP -> all outputs 0 immediately. After release with enabled high -> fresh transfer from capture.
- Re-arm: hold enabled high after done -> no second transfer. Drop enabled 1 cycle, raise again -> done=0 and a full retransmission.

Source files
------------

// File: rtl/digit_stream_pkg.sv
`default_nettype none
// ============================================================================
// Package  : digit_stream_pkg
// Brief    : Shared states, constants and BCD sizing for digit_stream_tx.
// Revision : 1.0
// ============================================================================
package digit_stream_pkg;

    localparam int c_NIBBLE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_SELECT  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_GAP     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_HOLD = 2'd1,
        PH_GAP  = 2'd2
    } phase_t;

    // Decimal digits of 2^num_w-1 is floor(num_w*log10(2))+1, four bits each.
    function automatic int dd_bcd_width(input int num_w);
        return c_NIBBLE_W * (((num_w * 30103) / 100000) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_stream_if.sv
`default_nettype none
// ============================================================================
// Interface : digit_stream_if
// Brief     : Request/value inputs and symbol bus outputs of digit_stream_tx.
// Revision  : 1.0
// ============================================================================
interface digit_stream_if #(
    parameter int NUM_W = 32,
    parameter int SYM_W = 4
);
    logic             enabled;
    logic [NUM_W-1:0] num;
    logic [SYM_W-1:0] sym_out;
    logic             controlOut;
    logic             busy;
    logic             done;

    modport master (
        output enabled,
        output num,
        input  sym_out,
        input  controlOut,
        input  busy,
        input  done
    );

    modport slave (
        input  enabled,
        input  num,
        output sym_out,
        output controlOut,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/symbol_timer.sv
`default_nettype none
// ============================================================================
// Module   : symbol_timer
// Brief    : Holds each symbol for HOLD_CYCLES, then idles GAP_CYCLES before
//            picking up the next one; start low clears it immediately.
// Revision : 1.0
// ============================================================================
module symbol_timer
    import digit_stream_pkg::*;
#(
    parameter int SYM_W       = 4,
    parameter int HOLD_CYCLES = 1200000,
    parameter int GAP_CYCLES  = 120000
) (
    input  wire logic             hwclk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [SYM_W-1:0] sym_in,
    input  wire logic             last,
    output logic      [SYM_W-1:0] sym_out,
    output logic                  controlOut,
    output logic                  done_pulse
);

    localparam int c_MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LD  = c_CNT_W'(GAP_CYCLES - 1);

    phase_t             r_phase;
    logic [c_CNT_W-1:0] r_cnt;
    logic [SYM_W-1:0]   r_sym;
    logic               r_ctl;

    // Asserted in the final hold cycle so the owner can advance its index
    // before the gap ends and the next symbol is loaded.
    assign done_pulse = (r_phase == PH_HOLD) && (r_cnt == '0);
    assign sym_out    = r_sym;
    assign controlOut = r_ctl;

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_IDLE;
            r_cnt   <= '0;
            r_sym   <= '0;
            r_ctl   <= 1'b0;
        end else if (!start) begin
            r_phase <= PH_IDLE;
            r_cnt   <= '0;
            r_sym   <= '0;
            r_ctl   <= 1'b0;
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    r_sym   <= sym_in;
                    r_ctl   <= 1'b1;
                    r_cnt   <= c_HOLD_LD;
                    r_phase <= PH_HOLD;
                end
                PH_HOLD: begin
                    if (r_cnt == '0) begin
                        r_sym <= '0;
                        r_ctl <= 1'b0;
                        if (last) begin
                            r_phase <= PH_IDLE;
                        end else begin
                            r_cnt   <= c_GAP_LD;
                            r_phase <= PH_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PH_GAP: begin
                    if (r_cnt == '0) begin
                        r_sym   <= sym_in;
                        r_ctl   <= 1'b1;
                        r_cnt   <= c_HOLD_LD;
                        r_phase <= PH_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/digit_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : digit_stream_tx
// Brief    : Captures a binary value, converts it to BCD by double-dabble and
//            sends the digits one timed symbol at a time.
// Revision : 1.0
// ============================================================================
module digit_stream_tx
    import digit_stream_pkg::*;
#(
    parameter int NUM_W       = 32,
    parameter int NUM_DIGITS  = 6,
    parameter int SYM_W       = 4,
    parameter int HOLD_CYCLES = 1200000,
    parameter int GAP_CYCLES  = 120000,
    parameter int MSD_FIRST   = 1,
    parameter int SUPPRESS_LZ = 0
) (
    input  wire logic     hwclk,
    input  wire logic     rst,
    digit_stream_if.slave bus
);

    // Only the low NUM_DIGITS nibbles are kept; add-3 corrections never
    // propagate downward, so the kept nibbles equal num mod 10^NUM_DIGITS.
    localparam int c_BCD_FULL = dd_bcd_width(NUM_W);
    localparam int c_BCD_W    = (c_BCD_FULL < c_NIBBLE_W * NUM_DIGITS) ?
                                c_BCD_FULL : c_NIBBLE_W * NUM_DIGITS;
    localparam int c_IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_BIT_W    = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(NUM_DIGITS - 1);

    state_t              r_state;
    logic [NUM_W-1:0]    r_shift;
    logic [c_BCD_W-1:0]  r_bcd;
    logic [c_BIT_W-1:0]  r_bitcnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_IDX_W-1:0]  r_last_idx;
    logic                r_busy;
    logic                r_done;

    logic [c_NIBBLE_W-1:0] w_digit [NUM_DIGITS];
    logic [c_BCD_W-1:0]    w_bcd_adj;
    logic [c_BCD_W-1:0]    w_bcd_next;
    logic [c_IDX_W-1:0]    w_top_nz;
    logic [c_IDX_W-1:0]    w_first_idx;
    logic [c_IDX_W-1:0]    w_final_idx;
    logic [c_IDX_W-1:0]    w_idx_step;
    logic [SYM_W-1:0]      w_sym_in;
    logic [SYM_W-1:0]      w_sym_out;
    logic                  w_ctl;
    logic                  w_slot_end;
    logic                  w_last;
    logic                  w_run;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (c_NIBBLE_W * (gi + 1) <= c_BCD_W) begin : g_conv
                assign w_digit[gi] = r_bcd[c_NIBBLE_W*gi +: c_NIBBLE_W];
            end else begin : g_pad
                assign w_digit[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < c_BCD_W / c_NIBBLE_W; i++) begin
            if (r_bcd[c_NIBBLE_W*i +: c_NIBBLE_W] >= 4'd5) begin
                w_bcd_adj[c_NIBBLE_W*i +: c_NIBBLE_W] = r_bcd[c_NIBBLE_W*i +: c_NIBBLE_W] + 4'd3;
            end
        end
        w_bcd_next = c_BCD_W'({w_bcd_adj, r_shift[NUM_W-1]});
    end

    always_comb begin
        w_top_nz = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_digit[i] != '0) begin
                w_top_nz = c_IDX_W'(i);
            end
        end
    end

    assign w_first_idx = (MSD_FIRST != 0) ? ((SUPPRESS_LZ != 0) ? w_top_nz : c_IDX_MAX) : '0;
    assign w_final_idx = (MSD_FIRST != 0) ? '0 : ((SUPPRESS_LZ != 0) ? w_top_nz : c_IDX_MAX);
    assign w_idx_step  = (MSD_FIRST != 0) ? (r_idx - 1'b1) : (r_idx + 1'b1);
    assign w_last      = (r_idx == r_last_idx);
    assign w_sym_in    = SYM_W'(w_digit[r_idx]);
    assign w_run       = bus.enabled && ((r_state == ST_HOLD) || (r_state == ST_GAP));

    symbol_timer #(
        .SYM_W       (SYM_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_symbol_timer (
        .hwclk      (hwclk),
        .rst        (rst),
        .start      (w_run),
        .sym_in     (w_sym_in),
        .last       (w_last),
        .sym_out    (w_sym_out),
        .controlOut (w_ctl),
        .done_pulse (w_slot_end)
    );

    assign bus.sym_out    = w_sym_out;
    assign bus.controlOut = w_ctl;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_bitcnt   <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.enabled) begin
                        r_shift  <= bus.num;
                        r_bcd    <= '0;
                        r_bitcnt <= c_BIT_W'(NUM_W - 1);
                        r_busy   <= 1'b1;
                        r_state  <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (!bus.enabled) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_bcd   <= w_bcd_next;
                        r_shift <= r_shift << 1;
                        if (r_bitcnt == '0) begin
                            r_state <= ST_SELECT;
                        end else begin
                            r_bitcnt <= r_bitcnt - 1'b1;
                        end
                    end
                end
                ST_SELECT: begin
                    if (!bus.enabled) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx      <= w_first_idx;
                        r_last_idx <= w_final_idx;
                        r_state    <= ST_HOLD;
                    end
                end
                // With one-cycle holds the slot can end while still in GAP.
                ST_HOLD, ST_GAP: begin
                    if (!bus.enabled) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_slot_end) begin
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= w_idx_step;
                            r_state <= ST_GAP;
                        end
                    end else if ((r_state == ST_GAP) && w_ctl) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_DONE: begin
                    if (!bus.enabled) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_stream_tx
// Brief    : Randomised self-checking bench for three digit_stream_tx setups.
// Revision : 1.0
// ============================================================================
module tb_digit_stream_tx;

    localparam int c_NW   = 20;
    localparam int c_HOLD = 4;
    localparam int c_GAP  = 2;
    localparam int c_LAT  = c_NW + 2;
    localparam int c_SLOT = c_HOLD + c_GAP;

    // Per-instance configuration: 0 = MSD first, 1 = LSD first with zero
    // suppression, 2 = three digits on a 3-bit bus.
    localparam int c_ND   [3] = '{6, 6, 3};
    localparam int c_MSD  [3] = '{1, 0, 1};
    localparam int c_SLZ  [3] = '{0, 1, 0};
    localparam int c_SYMW [3] = '{4, 4, 3};

    logic hwclk;
    logic rst;
    logic              en   [3];
    logic [c_NW-1:0]   numv [3];
    logic [3:0]        o_sym  [3];
    logic              o_ctl  [3];
    logic              o_busy [3];
    logic              o_done [3];

    int n_cmp;
    int n_err;
    int exp_sym [10];
    int exp_n;

    digit_stream_if #(.NUM_W(c_NW), .SYM_W(4)) bus0 ();
    digit_stream_if #(.NUM_W(c_NW), .SYM_W(4)) bus1 ();
    digit_stream_if #(.NUM_W(c_NW), .SYM_W(3)) bus2 ();

    assign bus0.enabled = en[0];
    assign bus0.num     = numv[0];
    assign bus1.enabled = en[1];
    assign bus1.num     = numv[1];
    assign bus2.enabled = en[2];
    assign bus2.num     = numv[2];

    assign o_sym[0]  = bus0.sym_out;
    assign o_sym[1]  = bus1.sym_out;
    assign o_sym[2]  = {1'b0, bus2.sym_out};
    assign o_ctl[0]  = bus0.controlOut;
    assign o_ctl[1]  = bus1.controlOut;
    assign o_ctl[2]  = bus2.controlOut;
    assign o_busy[0] = bus0.busy;
    assign o_busy[1] = bus1.busy;
    assign o_busy[2] = bus2.busy;
    assign o_done[0] = bus0.done;
    assign o_done[1] = bus1.done;
    assign o_done[2] = bus2.done;

    digit_stream_tx #(
        .NUM_W(c_NW), .NUM_DIGITS(6), .SYM_W(4), .HOLD_CYCLES(c_HOLD),
        .GAP_CYCLES(c_GAP), .MSD_FIRST(1), .SUPPRESS_LZ(0)
    ) u_dut0 (.hwclk(hwclk), .rst(rst), .bus(bus0));

    digit_stream_tx #(
        .NUM_W(c_NW), .NUM_DIGITS(6), .SYM_W(4), .HOLD_CYCLES(c_HOLD),
        .GAP_CYCLES(c_GAP), .MSD_FIRST(0), .SUPPRESS_LZ(1)
    ) u_dut1 (.hwclk(hwclk), .rst(rst), .bus(bus1));

    digit_stream_tx #(
        .NUM_W(c_NW), .NUM_DIGITS(3), .SYM_W(3), .HOLD_CYCLES(c_HOLD),
        .GAP_CYCLES(c_GAP), .MSD_FIRST(1), .SUPPRESS_LZ(0)
    ) u_dut2 (.hwclk(hwclk), .rst(rst), .bus(bus2));

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp_v);
        end
    endtask

    // {busy, done, controlOut, sym[3:0]}
    function automatic logic [6:0] obs_of(input int d);
        return {o_busy[d], o_done[d], o_ctl[d], o_sym[d]};
    endfunction

    // Digit list straight from decimal arithmetic and the ordering rules.
    function automatic void model(input int d, input int unsigned v);
        int unsigned digs [10];
        int unsigned p;
        int top;
        int cnt;
        int di;
        p   = 1;
        top = 0;
        for (int i = 0; i < c_ND[d]; i++) begin
            digs[i] = (v / p) % 10;
            if (digs[i] != 0) top = i;
            p = p * 10;
        end
        cnt   = (c_SLZ[d] != 0) ? top + 1 : c_ND[d];
        exp_n = cnt;
        for (int j = 0; j < cnt; j++) begin
            di         = (c_MSD[d] != 0) ? (cnt - 1 - j) : j;
            exp_sym[j] = int'(digs[di]) % (1 << c_SYMW[d]);
        end
    endfunction

    function automatic int end_cycle();
        return c_LAT + (exp_n - 1) * c_SLOT + c_HOLD;
    endfunction

    // Expected bus state sampled c cycles after the capture edge.
    function automatic logic [6:0] expect_at(input int c);
        int rel;
        if (c >= end_cycle()) return 7'b010_0000;
        if (c >= c_LAT) begin
            rel = c - c_LAT;
            if ((rel % c_SLOT) < c_HOLD)
                return {3'b101, 4'(exp_sym[rel / c_SLOT])};
        end
        return 7'b100_0000;
    endfunction

    // Called at a negedge with the DUT idle; runs from capture to done+extra.
    task automatic run_xfer(input int d, input int unsigned v, input int extra);
        model(d, v);
        numv[d] = c_NW'(v);
        en[d]   = 1'b1;
        for (int c = 0; c <= end_cycle() + extra; c++) begin
            @(negedge hwclk);
            check_eq("xfer", 32'(obs_of(d)), 32'(expect_at(c)));
            if (c == 0) numv[d] = c_NW'($urandom);
        end
    endtask

    task automatic release_en(input int d);
        en[d] = 1'b0;
        @(negedge hwclk);
        check_eq("release", 32'(obs_of(d)), 32'd0);
    endtask

    task automatic abort_xfer(input int d, input int unsigned v, input int at);
        model(d, v);
        numv[d] = c_NW'(v);
        en[d]   = 1'b1;
        for (int c = 0; c <= at; c++) begin
            @(negedge hwclk);
            check_eq("pre_abort", 32'(obs_of(d)), 32'(expect_at(c)));
        end
        en[d] = 1'b0;
        repeat (3) begin
            @(negedge hwclk);
            check_eq("abort", 32'(obs_of(d)), 32'd0);
        end
    endtask

    // Leaves enabled high so the caller can check the fresh transfer.
    task automatic reset_mid(input int d, input int unsigned v, input int at);
        model(d, v);
        numv[d] = c_NW'(v);
        en[d]   = 1'b1;
        for (int c = 0; c <= at; c++) begin
            @(negedge hwclk);
            check_eq("pre_rst", 32'(obs_of(d)), 32'(expect_at(c)));
        end
        rst = 1'b1;
        #1;
        check_eq("async_rst", 32'(obs_of(d)), 32'd0);
        @(negedge hwclk);
        check_eq("rst_hold", 32'(obs_of(d)), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int unsigned v;
        int at;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            en[i]   = 1'b0;
            numv[i] = '0;
        end
        repeat (3) @(negedge hwclk);
        for (int i = 0; i < 3; i++) check_eq("reset", 32'(obs_of(i)), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge hwclk);
        for (int i = 0; i < 3; i++) check_eq("idle", 32'(obs_of(i)), 32'd0);

        // MSD first, then enabled held long past done: no retransmission.
        run_xfer(0, 123456, 30);
        release_en(0);
        run_xfer(0, 123456, 2);
        release_en(0);

        // LSD first with zero suppression.
        run_xfer(1, 907, 1);
        release_en(1);
        run_xfer(1, 0, 1);
        release_en(1);

        // Modulo 10^3 and 3-bit truncation.
        run_xfer(2, 98765, 1);
        release_en(2);
        run_xfer(2, 89, 1);
        release_en(2);

        // Abort during the third hold, then a fresh value.
        abort_xfer(0, 123456, c_LAT + 2 * c_SLOT + 1);
        run_xfer(0, 42, 1);
        release_en(0);

        // Asynchronous reset mid-gap and mid-hold, restarting with enabled high.
        reset_mid(0, 555555, c_LAT + c_HOLD);
        run_xfer(0, 314159, 1);
        release_en(0);
        reset_mid(1, 120034, c_LAT + 1);
        run_xfer(1, 100200, 1);
        release_en(1);

        for (int it = 0; it < 12; it++) begin
            d = $urandom_range(0, 2);
            v = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 20'hFFFFF) : $urandom_range(0, 999);
            if ($urandom_range(0, 2) == 0) begin
                model(d, v);
                at = $urandom_range(0, end_cycle() - 1);
                abort_xfer(d, v, at);
            end else begin
                run_xfer(d, v, $urandom_range(0, 3));
                release_en(d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
